// File: rtl/luhn_nibble_feeder.sv
// rtl/luhn_nibble_feeder.sv - buffers a byte message, then feeds its size and nibbles to the Luhn checker
// Ports:
//   clock, rst                         rising-edge clock, synchronous active-high reset
//   in_data/in_last/in_valid/in_ready  byte stream in, in_last marks the final byte
//   size/size_valid/size_ready         nibble count of the buffered message
//   data/data_valid/data_ready         nibble stream out, high nibble first
//   trunc                              current message overflowed MAX_BYTES
module luhn_nibble_feeder #(
  parameter int MAX_BYTES = 16,
  parameter int SIZE_W    = 8
) (
  input  logic              clock,
  input  logic              rst,
  input  logic [7:0]        in_data,
  input  logic              in_last,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [SIZE_W-1:0] size,
  output logic              size_valid,
  input  logic              size_ready,
  output logic [3:0]        data,
  output logic              data_valid,
  input  logic              data_ready,
  output logic              trunc
);

  localparam int         AW      = (MAX_BYTES > 1) ? $clog2(MAX_BYTES) : 1;
  localparam logic [7:0] MAX_CNT = 8'(MAX_BYTES);

  typedef enum logic [1:0] {S_LOAD, S_SIZE, S_DATA} state_t;

  state_t              state_q, state_d;
  logic [7:0]          count_q, count_d;
  logic [SIZE_W-1:0]   idx_q, idx_d;
  logic [SIZE_W-1:0]   size_q, size_d;
  logic [3:0]          data_q, data_d;
  logic                in_ready_q, in_ready_d;
  logic                size_valid_q, size_valid_d;
  logic                data_valid_q, data_valid_d;
  logic                trunc_q, trunc_d;

  logic [7:0]          mem_q [MAX_BYTES];
  logic                mem_we;
  logic [7:0]          stored;

  // Nibble to present next: nibble 0 when leaving SIZE, otherwise idx+1.
  // Registering it keeps data stable and aligned with data_valid.
  logic [SIZE_W-1:0]   nib_idx;
  logic [7:0]          nib_byte;
  logic [3:0]          nib_sel;

  always_comb begin
    nib_idx  = (state_q == S_SIZE) ? '0 : idx_q + 1'b1;
    nib_byte = mem_q[AW'(nib_idx >> 1)];
    nib_sel  = nib_idx[0] ? nib_byte[3:0] : nib_byte[7:4];
  end

  always_comb begin
    state_d      = state_q;
    count_d      = count_q;
    idx_d        = idx_q;
    size_d       = size_q;
    data_d       = data_q;
    in_ready_d   = in_ready_q;
    size_valid_d = size_valid_q;
    data_valid_d = data_valid_q;
    trunc_d      = trunc_q;
    mem_we       = 1'b0;
    stored       = count_q;

    case (state_q)
      S_LOAD: begin
        if (in_valid) begin
          if (count_q < MAX_CNT) begin
            mem_we = 1'b1;
            stored = count_q + 8'd1;
          end else begin
            trunc_d = 1'b1;
          end
          count_d = stored;
          if (in_last) begin
            size_d       = SIZE_W'({stored[6:0], 1'b0});
            state_d      = S_SIZE;
            in_ready_d   = 1'b0;
            size_valid_d = 1'b1;
          end
        end
      end
      S_SIZE: begin
        if (size_ready) begin
          state_d      = S_DATA;
          idx_d        = '0;
          size_valid_d = 1'b0;
          data_valid_d = 1'b1;
          data_d       = nib_sel;
        end
      end
      S_DATA: begin
        if (data_ready) begin
          if (idx_q == size_q - 1'b1) begin
            state_d      = S_LOAD;
            count_d      = '0;
            trunc_d      = 1'b0;
            data_valid_d = 1'b0;
            in_ready_d   = 1'b1;
          end else begin
            idx_d  = idx_q + 1'b1;
            data_d = nib_sel;
          end
        end
      end
      default: begin
        state_d = S_LOAD;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (rst) begin
      state_q      <= S_LOAD;
      count_q      <= '0;
      idx_q        <= '0;
      size_q       <= '0;
      data_q       <= '0;
      in_ready_q   <= 1'b1;
      size_valid_q <= 1'b0;
      data_valid_q <= 1'b0;
      trunc_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      idx_q        <= idx_d;
      size_q       <= size_d;
      data_q       <= data_d;
      in_ready_q   <= in_ready_d;
      size_valid_q <= size_valid_d;
      data_valid_q <= data_valid_d;
      trunc_q      <= trunc_d;
    end
  end

  // Buffer contents need no reset; stale bytes are never read.
  always_ff @(posedge clock) begin
    if (mem_we) begin
      mem_q[AW'(count_q)] <= in_data;
    end
  end

  assign in_ready   = in_ready_q;
  assign size       = size_q;
  assign size_valid = size_valid_q;
  assign data       = data_q;
  assign data_valid = data_valid_q;
  assign trunc      = trunc_q;

endmodule

// File: tb/tb_luhn_nibble_feeder.sv
// tb/tb_luhn_nibble_feeder.sv - directed self-checking bench for luhn_nibble_feeder
module tb_luhn_nibble_feeder;

  localparam int MAXB = 16;

  logic       clock = 1'b0;
  logic       rst;
  logic [7:0] in_data;
  logic       in_last;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] size;
  logic       size_valid;
  logic       size_ready;
  logic [3:0] data;
  logic       data_valid;
  logic       data_ready;
  logic       trunc;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0] msg [0:31];
  int         msg_len;
  logic [3:0] exp_nib [0:63];
  int         nib_len;
  logic [7:0] exp_size;

  always #5 clock = ~clock;

  luhn_nibble_feeder #(.MAX_BYTES(MAXB), .SIZE_W(8)) dut (
    .clock      (clock),
    .rst        (rst),
    .in_data    (in_data),
    .in_last    (in_last),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .size       (size),
    .size_valid (size_valid),
    .size_ready (size_ready),
    .data       (data),
    .data_valid (data_valid),
    .data_ready (data_ready),
    .trunc      (trunc)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Expected nibbles from the stored (non-truncated) bytes, high nibble first.
  task automatic fill_expect();
    int stored_n;
    logic [7:0] b;
    stored_n = (msg_len > MAXB) ? MAXB : msg_len;
    nib_len  = 2 * stored_n;
    exp_size = 8'(nib_len);
    for (int i = 0; i < stored_n; i++) begin
      b = msg[i];
      exp_nib[2*i]   = b[7:4];
      exp_nib[2*i+1] = b[3:0];
    end
  endtask

  task automatic send_msg();
    int w;
    for (int i = 0; i < msg_len; i++) begin
      in_data  = msg[i];
      in_last  = (i == msg_len - 1);
      in_valid = 1'b1;
      w = 0;
      while (!in_ready && w < 50) begin
        step();
        w++;
      end
      check_eq("in_ready_load", in_ready, 1);
      step();
      check_eq("trunc_load", trunc, (i >= MAXB));
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    check_eq("size_valid_after_last", size_valid, 1);
    check_eq("size_after_last", size, exp_size);
    check_eq("in_ready_after_last", in_ready, 0);
    check_eq("data_valid_in_size", data_valid, 0);
  endtask

  task automatic recv_msg(input bit stall, input logic exp_trunc, input int n_take);
    int s;
    size_ready = 1'b1;
    step();
    size_ready = 1'b0;
    check_eq("size_valid_drop", size_valid, 0);
    for (int k = 0; k < n_take; k++) begin
      if (stall) begin
        s = $urandom_range(0, 7);
        data_ready = 1'b0;
        for (int j = 0; j < s; j++) begin
          check_eq("data_valid_stall", data_valid, 1);
          check_eq("data_stable", data, exp_nib[k]);
          step();
        end
      end
      data_ready = 1'b1;
      check_eq("data_valid", data_valid, 1);
      check_eq("nibble", data, exp_nib[k]);
      check_eq("size_valid_excl", size_valid, 0);
      check_eq("trunc_data", trunc, exp_trunc);
      step();
    end
    data_ready = 1'b0;
    if (n_take == nib_len) begin
      check_eq("data_valid_end", data_valid, 0);
      check_eq("in_ready_end", in_ready, 1);
      check_eq("trunc_end", trunc, 0);
    end
  endtask

  task automatic check_idle(input string tag);
    check_eq({tag, "_in_ready"}, in_ready, 1);
    check_eq({tag, "_size_valid"}, size_valid, 0);
    check_eq({tag, "_data_valid"}, data_valid, 0);
    check_eq({tag, "_size"}, size, 0);
    check_eq({tag, "_trunc"}, trunc, 0);
  endtask

  initial begin
    rst        = 1'b1;
    in_data    = '0;
    in_last    = 1'b0;
    in_valid   = 1'b0;
    size_ready = 1'b0;
    data_ready = 1'b0;
    step();
    step();
    rst = 1'b0;
    check_idle("reset");
    check_eq("reset_data", data, 0);

    // 1: four bytes, checker always ready; hand-written nibble table
    msg[0] = 8'hA3; msg[1] = 8'hDC; msg[2] = 8'h15; msg[3] = 8'h97;
    msg_len = 4;
    nib_len = 8;
    exp_size = 8'd8;
    exp_nib[0] = 4'hA; exp_nib[1] = 4'h3; exp_nib[2] = 4'hD; exp_nib[3] = 4'hC;
    exp_nib[4] = 4'h1; exp_nib[5] = 4'h5; exp_nib[6] = 4'h9; exp_nib[7] = 4'h7;
    send_msg();
    recv_msg(1'b0, 1'b0, nib_len);

    // 2: same message with random back-pressure between nibbles
    send_msg();
    recv_msg(1'b1, 1'b0, nib_len);

    // 3: single-byte messages back to back
    msg[0] = 8'h5E; msg_len = 1;
    fill_expect();
    check_eq("t3_size_model", exp_size, 8'd2);
    send_msg();
    recv_msg(1'b0, 1'b0, nib_len);
    msg[0] = 8'h0F;
    fill_expect();
    send_msg();
    recv_msg(1'b0, 1'b0, nib_len);

    // 4: 18 bytes into a 16-byte buffer
    for (int i = 0; i < 18; i++) msg[i] = 8'(i);
    msg_len = 18;
    fill_expect();
    send_msg();
    check_eq("t4_size", size, 8'd32);
    check_eq("t4_trunc", trunc, 1);
    recv_msg(1'b0, 1'b1, nib_len);

    // 5: size_ready held low; in_valid toggling must be ignored
    msg[0] = 8'hA3; msg[1] = 8'hDC; msg[2] = 8'h15; msg[3] = 8'h97;
    msg_len = 4;
    fill_expect();
    send_msg();
    in_valid = 1'b1;
    in_data  = 8'hFF;
    in_last  = 1'b1;
    for (int c = 0; c < 10; c++) begin
      check_eq("t5_size_valid", size_valid, 1);
      check_eq("t5_size", size, 8'd8);
      check_eq("t5_in_ready", in_ready, 0);
      check_eq("t5_data_valid", data_valid, 0);
      step();
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    recv_msg(1'b0, 1'b0, nib_len);

    // 6: reset mid-DATA, then a fresh one-byte message
    send_msg();
    recv_msg(1'b0, 1'b0, 3);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_idle("t6_reset");
    msg[0] = 8'h7C; msg_len = 1;
    fill_expect();
    send_msg();
    recv_msg(1'b0, 1'b0, nib_len);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
